// File: rtl/compy_bus_pkg.sv
// Shared types and constants for the VRAM/CPU memory bus arbiter.
// Holds the FSM state encoding, the bus owner and the default parameters.
package compy_bus_pkg;

    localparam int MEM_AW               = 19;
    localparam int DEF_CPU_STARVE_LIMIT = 4;
    localparam int DEF_MEM_TIMEOUT      = 64;

    localparam logic [MEM_AW-1:0] VRAM_BASE_DEFAULT = 19'h20000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on memory and flags the last allowed cycle.
// The count restarts whenever the arbiter is not waiting.
module mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = active ? wait_cnt_q + CW'(1) : '0;
        // Fires on the TIMEOUT-th waiting cycle so the request is held exactly TIMEOUT cycles.
        expired    = active && (wait_cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Arbitrates one memory port between a video read stream and a CPU master,
// with bounded CPU starvation and a memory-acknowledge watchdog.
module vram_bus_arbiter
    import compy_bus_pkg::*;
#(
    parameter int                CPU_STARVE_LIMIT = DEF_CPU_STARVE_LIMIT,
    parameter int                MEM_TIMEOUT      = DEF_MEM_TIMEOUT,
    parameter logic [MEM_AW-1:0] VRAM_BASE        = VRAM_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        vid_page,
    input  logic [13:0]       vid_addr,
    input  logic              vid_rd_req,
    output logic              vid_rd_ack,
    output logic [7:0]        vid_data,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              timeout_err
);

    localparam int SW = ($clog2(CPU_STARVE_LIMIT + 1) < 3) ? 3 : $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              is_wr_q, is_wr_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic              mem_wr_req_q, mem_wr_req_d;
    logic              vid_rd_ack_q, vid_rd_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [7:0]        vid_data_q, vid_data_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              timeout_err_q, timeout_err_d;

    logic              expired;
    logic              cpu_starved;
    logic [7:0]        done_data;
    logic [MEM_AW-1:0] vid_mem_addr;

    mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .active  (state_q == MEM_WAIT),
        .expired (expired)
    );

    assign vid_mem_addr = VRAM_BASE + MEM_AW'({vid_page, 9'b0}) + MEM_AW'(vid_addr);
    assign cpu_starved  = cpu_req && (starve_cnt_q == STARVE_MAX);
    assign done_data    = mem_ack ? mem_rdata : 8'hFF;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        is_wr_d       = is_wr_q;
        starve_cnt_d  = starve_cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_req_d  = mem_wr_req_q;
        vid_data_d    = vid_data_q;
        cpu_rdata_d   = cpu_rdata_q;
        vid_rd_ack_d  = 1'b0;
        cpu_ack_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cpu_req) starve_cnt_d = '0;
                if (vid_rd_req && !cpu_starved) begin
                    state_d      = MEM_WAIT;
                    owner_d      = OWN_VID;
                    is_wr_d      = 1'b0;
                    mem_addr_d   = vid_mem_addr;
                    mem_wdata_d  = 8'h00;
                    mem_rd_req_d = 1'b1;
                    // Only reachable below the limit, so the increment never wraps.
                    if (cpu_req) starve_cnt_d = starve_cnt_q + SW'(1);
                end else if (cpu_req) begin
                    state_d      = MEM_WAIT;
                    owner_d      = OWN_CPU;
                    is_wr_d      = cpu_we;
                    mem_addr_d   = {3'b000, cpu_addr};
                    mem_wdata_d  = cpu_wdata;
                    mem_rd_req_d = !cpu_we;
                    mem_wr_req_d = cpu_we;
                    starve_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                // A real mem_ack takes priority over a simultaneous expiry.
                if (mem_ack || expired) begin
                    state_d       = COMPLETE;
                    mem_rd_req_d  = 1'b0;
                    mem_wr_req_d  = 1'b0;
                    timeout_err_d = !mem_ack;
                    if (owner_q == OWN_VID) begin
                        vid_rd_ack_d = 1'b1;
                        vid_data_d   = done_data;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!is_wr_q) cpu_rdata_d = done_data;
                    end
                end
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_VID;
            is_wr_q       <= 1'b0;
            starve_cnt_q  <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            vid_rd_ack_q  <= 1'b0;
            cpu_ack_q     <= 1'b0;
            vid_data_q    <= '0;
            cpu_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            is_wr_q       <= is_wr_d;
            starve_cnt_q  <= starve_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            vid_rd_ack_q  <= vid_rd_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            vid_data_q    <= vid_data_d;
            cpu_rdata_q   <= cpu_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign vid_rd_ack  = vid_rd_ack_q;
    assign vid_data    = vid_data_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter: stimulus queues expected memory
// requests and acks; a monitor/memory responder pops and compares them.
module tb_vram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vid_page;
    logic [13:0] vid_addr;
    logic        vid_rd_req;
    logic        vid_rd_ack;
    logic [7:0]  vid_data;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_req;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        timeout_err;

    vram_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_page(vid_page), .vid_addr(vid_addr), .vid_rd_req(vid_rd_req),
        .vid_rd_ack(vid_rd_ack), .vid_data(vid_data),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_req(cpu_req),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_cpu; logic [7:0] data; bit tmo; int len; } ack_exp_t;
    typedef struct { logic [18:0] addr; bit we; logic [7:0] wdata; } mem_exp_t;

    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 1;   // cycle of the request on which memory acks; 0 = never
    bit stray_ack = 1'b0;
    bit prev_req  = 1'b0;
    bit req_now   = 1'b0;
    int req_cnt   = 0;
    int last_len  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and memory responder; DUT outputs only move on posedge.
    initial begin : monitor
        mem_exp_t me;
        ack_exp_t ae;
        forever begin
            @(negedge clk);
            req_now = mem_rd_req | mem_wr_req;
            if (req_now && !prev_req) begin
                chk("rd_wr_exclusive", 32'(mem_rd_req & mem_wr_req), 32'd0);
                if (mem_q.size() == 0) chk("mem_unexpected_req", 32'(mem_q.size()), 32'd1);
                else begin
                    me = mem_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(me.addr));
                    chk("mem_wr_req", 32'(mem_wr_req), 32'(me.we));
                    if (me.we) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
                end
            end
            if (vid_rd_ack || cpu_ack) begin
                chk("ack_onehot", 32'(vid_rd_ack & cpu_ack), 32'd0);
                if (ack_q.size() == 0) chk("ack_unexpected", 32'(ack_q.size()), 32'd1);
                else begin
                    ae = ack_q.pop_front();
                    chk("ack_owner_cpu", 32'(cpu_ack), 32'(ae.is_cpu));
                    chk("ack_data", ae.is_cpu ? 32'(cpu_rdata) : 32'(vid_data), 32'(ae.data));
                    chk("timeout_err", 32'(timeout_err), 32'(ae.tmo));
                    chk("req_hold_len", 32'(last_len), 32'(ae.len));
                    chk("ack_after_req", 32'({prev_req, req_now}), 32'b10);
                end
            end else if (timeout_err) begin
                chk("tmo_without_ack", 32'(timeout_err), 32'd0);
            end
            if (req_now) begin
                req_cnt  = prev_req ? req_cnt + 1 : 1;
                last_len = req_cnt;
            end else req_cnt = 0;
            mem_ack   = (req_now && ack_delay != 0 && req_cnt == ack_delay) || stray_ack;
            mem_rdata = mem_ack ? (mem_addr[7:0] ^ 8'h5A) : 8'h00;
            prev_req  = req_now;
        end
    end

    task automatic wait_acks(input string name, input int n);
        int got = 0;
        for (int i = 0; i < 400 && got < n; i++) begin
            @(negedge clk);
            if (vid_rd_ack || cpu_ack) got++;
        end
        if (got < n) chk({name, "_ack_wait"}, 32'(got), 32'(n));
    endtask

    task automatic vid_txn(input string name, input logic [7:0] pg, input logic [13:0] ad,
                           input int dly, input logic [18:0] ea, input logic [7:0] ed,
                           input bit tmo, input int len);
        @(negedge clk);
        ack_delay = dly; vid_page = pg; vid_addr = ad; vid_rd_req = 1'b1;
        mem_q.push_back('{ea, 1'b0, 8'h00});
        ack_q.push_back('{1'b0, ed, tmo, len});
        wait_acks(name, 1);
        vid_rd_req = 1'b0;
    endtask

    task automatic cpu_txn(input string name, input logic [15:0] ad, input logic [7:0] wd,
                           input bit we, input int dly, input logic [7:0] ed);
        @(negedge clk);
        ack_delay = dly; cpu_addr = ad; cpu_wdata = wd; cpu_we = we; cpu_req = 1'b1;
        mem_q.push_back('{{3'b000, ad}, we, wd});
        ack_q.push_back('{1'b1, ed, 1'b0, dly});
        wait_acks(name, 1);
        cpu_req = 1'b0;
    endtask

    initial begin : stim
        bit seen;
        reset = 1'b1; vid_page = '0; vid_addr = '0; vid_rd_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vid_rd_ack", 32'(vid_rd_ack), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        reset = 1'b0;

        vid_txn("vid_basic", 8'h02, 14'h0010, 3, 19'h20410, 8'h4A, 1'b0, 3);
        cpu_txn("cpu_read", 16'h0077, 8'h00, 1'b0, 1, 8'h2D);
        cpu_txn("cpu_write", 16'h1234, 8'hA5, 1'b1, 2, 8'h2D);

        // Both masters hold requests: V,V,V,V,C,V,V,V,V,C
        @(negedge clk);
        ack_delay = 1; vid_page = 8'h01; vid_addr = 14'h0005;
        cpu_addr = 16'h00AB; cpu_we = 1'b0; cpu_wdata = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                mem_q.push_back('{19'h000AB, 1'b0, 8'h00});
                ack_q.push_back('{1'b1, 8'hF1, 1'b0, 1});
            end else begin
                mem_q.push_back('{19'h20205, 1'b0, 8'h00});
                ack_q.push_back('{1'b0, 8'h5F, 1'b0, 1});
            end
        end
        vid_rd_req = 1'b1; cpu_req = 1'b1;
        wait_acks("starve", 10);
        vid_rd_req = 1'b0; cpu_req = 1'b0;

        // mem_ack while idle must not produce any ack
        @(posedge clk); #2 stray_ack = 1'b1;
        @(posedge clk); #2 stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_no_ack", 32'(vid_rd_ack | cpu_ack | timeout_err), 32'd0);
        chk("stray_no_req", 32'(mem_rd_req | mem_wr_req), 32'd0);

        vid_txn("timeout", 8'h00, 14'h0100, 0, 19'h20100, 8'hFF, 1'b1, 64);
        vid_txn("collision", 8'h00, 14'h0101, 64, 19'h20101, 8'h5B, 1'b0, 64);

        // Reset in the second MEM_WAIT cycle drops the transaction silently
        @(negedge clk);
        ack_delay = 0; vid_page = 8'h03; vid_addr = 14'h0020; vid_rd_req = 1'b1;
        mem_q.push_back('{19'h20620, 1'b0, 8'h00});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_rd_req;
        end
        chk("rstw_req_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1; vid_rd_req = 1'b0;
        @(negedge clk);
        chk("rstw_rd_req_dropped", 32'(mem_rd_req), 32'd0);
        chk("rstw_no_ack", 32'(vid_rd_ack), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstw_still_idle", 32'(mem_rd_req | vid_rd_ack), 32'd0);

        vid_txn("after_reset", 8'h00, 14'h0003, 2, 19'h20003, 8'h59, 1'b0, 2);

        repeat (5) @(negedge clk);
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_bus_arbiter.md
VRAM_BUS_ARBITER -- requirements
Module: vram_bus_arbiter

Interface
REQ-001 Parameter CPU_STARVE_LIMIT, default 4: the maximum number of consecutive video grants allowed while a CPU request is pending.
REQ-002 Parameter MEM_TIMEOUT, default 64: the maximum number of cycles to wait for mem_ack before aborting.
REQ-003 Parameter VRAM_BASE, default 19'h20000: the memory offset added to every video address.
REQ-004 clk  in  1  single clock, rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vid_page  in  8  video page (512-byte units).
REQ-007 vid_addr  in  14  video offset within the page.
REQ-008 vid_rd_req  in  1  video read request, level.
REQ-009 vid_rd_ack  out  1  one-cycle pulse; vid_data is valid in the same cycle.
REQ-010 vid_data  out  8  video read data.
REQ-011 cpu_addr  in  16  CPU address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_we  in  1  1 = write, 0 = read.
REQ-014 cpu_req  in  1  CPU request, level.
REQ-015 cpu_ack  out  1  one-cycle pulse; cpu_rdata is valid in the same cycle.
REQ-016 cpu_rdata  out  8  CPU read data.
REQ-017 mem_addr  out  19  memory address.
REQ-018 mem_wdata  out  8  memory write data.
REQ-019 mem_rd_req  out  1  memory read request, level.
REQ-020 mem_wr_req  out  1  memory write request, level.
REQ-021 mem_ack  in  1  one-cycle completion pulse.
REQ-022 mem_rdata  in  8  memory read data, valid with mem_ack.
REQ-023 timeout_err  out  1  one-cycle pulse on a memory abort.

Function
REQ-024 States SHALL be IDLE, MEM_WAIT and COMPLETE.
REQ-025 IDLE arbitration:
- Video is granted when vid_rd_req=1, unless cpu_req=1 and starve_cnt==CPU_STARVE_LIMIT; the CPU is then granted.
- The CPU is granted when it is the only requester.
- When neither requests, the state stays IDLE.
REQ-026 On a grant, the arbiter SHALL register mem_addr, mem_wdata and the owner, and enter MEM_WAIT.
- mem_rd_req or mem_wr_req is asserted from the next cycle.
REQ-027 The video address SHALL be mem_addr = (VRAM_BASE + {vid_page,9'b0} + vid_addr) mod 2^19.
REQ-028 The CPU address SHALL be mem_addr = {3'b000, cpu_addr}; mem_wr_req is used when cpu_we=1, otherwise mem_rd_req.
- Video access SHALL always use mem_rd_req.
REQ-029 In MEM_WAIT, the memory request SHALL be held until mem_ack arrives. On the mem_ack cycle:
- drop the memory request;
- capture mem_rdata (only when the access was a read);
- enter COMPLETE.
REQ-030 COMPLETE SHALL last exactly one cycle, then return to IDLE.
- It pulses the owner's ack and drives the captured data onto that owner's data output.
- New requests are not sampled in COMPLETE, so the requester has one cycle to drop its req.
REQ-031 Latency: a request seen in IDLE at cycle 0 gives memory request at cycle 1, mem_ack at cycle k, requester ack at k+1, and IDLE at k+2.
REQ-032 starve_cnt (3 bits minimum) behaviour:
- increments, saturating, on each video grant while cpu_req=1;
- clears on a CPU grant;
- clears in any IDLE cycle with cpu_req=0.
REQ-033 Timeout:
- wait_cnt counts MEM_WAIT cycles.
- If it reaches MEM_TIMEOUT with no mem_ack, drop the memory request, use data 8'hFF, pulse timeout_err in the COMPLETE cycle, and still ack the owner.
REQ-034 mem_ack outside MEM_WAIT SHALL be ignored.
- If mem_ack arrives on the same cycle the timeout expires, mem_ack wins.
REQ-035 A CPU write SHALL return cpu_rdata unchanged.
REQ-036 mem_rd_req and mem_wr_req SHALL never both be 1.

Reset
REQ-037 Reset SHALL apply the following:
- state = IDLE;
- all outputs = 0;
- starve_cnt = 0 and wait_cnt = 0.
REQ-038 A reset during MEM_WAIT SHALL deassert the memory request on the next edge and lose the transaction.
- No ack is issued; the requester must reissue the request.

Structure
REQ-039 Package compy_bus_pkg SHALL hold:
- the state enum;
- VRAM_BASE and the default parameter values;
- the 19-bit memory address width constant.
REQ-040 The wait counter and expiry compare SHALL be one sub-module, mem_watchdog; the arbitration logic stays inline.

Verification
REQ-041 Video only: vid_page=8'h02, vid_addr=14'h0010, mem_ack 3 cycles after request.
- Response: mem_addr=19'h20410, mem_rd_req held 3 cycles, vid_rd_ack at cycle 4 with mem_rdata.
REQ-042 CPU write: cpu_addr=16'h1234, cpu_wdata=8'hA5, cpu_we=1.
- Response: mem_wr_req=1, mem_addr=19'h01234, mem_wdata=8'hA5, cpu_ack one cycle after mem_ack.
REQ-043 Starvation: both requesting continuously, CPU_STARVE_LIMIT=4.
- Response: grant order V,V,V,V,C,V,V,V,V,C.
REQ-044 Timeout: MEM_TIMEOUT=64, mem_ack never asserted.
- Response: request dropped after 64 cycles, ack with data 8'hFF, timeout_err pulse.
REQ-045 Collision: mem_ack on the exact expiry cycle.
- Response: real data returned, no timeout_err.
REQ-046 Reset mid-wait: reset asserted in cycle 2 of MEM_WAIT.
- Response: mem_rd_req=0 next edge, no ack; a new request after reset completes normally.
